// File: rtl/key_pad_emulator_pkg.sv
// rtl/key_pad_emulator_pkg.sv - shared types and constants for the keypad emulator
package key_pad_emulator_pkg;

  localparam int         KEY_CODE_W = 4;
  // Fibonacci feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BOUNCE_IN  = 2'd1,
    ST_HELD       = 2'd2,
    ST_BOUNCE_OUT = 2'd3
  } kp_state_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/key_pad_emulator_if.sv
// rtl/key_pad_emulator_if.sv - scanner/press-control bundle seen by the keypad emulator
interface key_pad_emulator_if #(
  parameter int HOLD_W = 16
) ();
  import key_pad_emulator_pkg::*;

  logic [3:0]            col;
  logic [3:0]            row;
  logic                  press_req;
  logic                  press_ready;
  logic [KEY_CODE_W-1:0] key_code;
  logic [HOLD_W-1:0]     hold_cycles;
  logic                  release_now;
  logic                  busy;
  logic                  contact;
  logic                  done;

  modport master (
    output col, press_req, key_code, hold_cycles, release_now,
    input  row, press_ready, busy, contact, done
  );

  modport slave (
    input  col, press_req, key_code, hold_cycles, release_now,
    output row, press_ready, busy, contact, done
  );

endinterface

// File: rtl/key_pad_emulator_lfsr8.sv
// rtl/key_pad_emulator_lfsr8.sv - free-running 8-bit Fibonacci LFSR feeding contact bounce
module lfsr8
  import key_pad_emulator_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] out
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out <= SEED;
    end else begin
      out <= lfsr_next(out);
    end
  end

endmodule

// File: rtl/key_pad_emulator.sv
// rtl/key_pad_emulator.sv - 4x4 keypad model: press FSM with make/break bounce and row decode
module key_pad_emulator
  import key_pad_emulator_pkg::*;
#(
  parameter int         BOUNCE_CYCLES = 16,
  parameter int         HOLD_W        = 16,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic             clk,
  input  logic             reset_n,
  key_pad_emulator_if.slave kp
);

  localparam int                BCNT_W    = $clog2(BOUNCE_CYCLES + 1);
  localparam logic [BCNT_W-1:0] BCNT_INIT = BCNT_W'(BOUNCE_CYCLES - 1);

  kp_state_t             state_q, state_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [HOLD_W-1:0]     hcnt_q, hcnt_d;
  logic [KEY_CODE_W-1:0] key_q, key_d;
  logic                  contact_q, contact_d;
  logic                  done_q, done_d;
  logic [7:0]            lfsr_q;
  logic [6:0]            unused_lfsr;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .out     (lfsr_q)
  );

  assign unused_lfsr = lfsr_q[7:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bcnt_q    <= '0;
      hcnt_q    <= '0;
      key_q     <= '0;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      hcnt_q    <= hcnt_d;
      key_q     <= key_d;
      contact_q <= contact_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    hcnt_d    = hcnt_q;
    key_d     = key_q;
    contact_d = contact_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        contact_d = 1'b0;
        if (kp.press_req) begin
          key_d   = kp.key_code;
          // hcnt doubles as the hold latch; a zero hold still gives one held cycle
          hcnt_d  = (kp.hold_cycles == '0) ? '0 : kp.hold_cycles - HOLD_W'(1);
          bcnt_d  = BCNT_INIT;
          state_d = ST_BOUNCE_IN;
        end
      end
      ST_BOUNCE_IN: begin
        if (bcnt_q == '0) begin
          contact_d = 1'b1;
          state_d   = ST_HELD;
        end else begin
          contact_d = lfsr_q[0];
          bcnt_d    = bcnt_q - BCNT_W'(1);
        end
      end
      ST_HELD: begin
        contact_d = 1'b1;
        if (hcnt_q == '0 || kp.release_now) begin
          contact_d = lfsr_q[0];
          bcnt_d    = BCNT_INIT;
          state_d   = ST_BOUNCE_OUT;
        end else begin
          hcnt_d = hcnt_q - HOLD_W'(1);
        end
      end
      ST_BOUNCE_OUT: begin
        if (bcnt_q == '0) begin
          contact_d = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          contact_d = lfsr_q[0];
          bcnt_d    = bcnt_q - BCNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Zero-latency switch matrix: only the latched column can connect, to the latched row
  assign kp.row         = (contact_q && kp.col[key_q[1:0]]) ? 4'(4'b0001 << key_q[3:2]) : 4'b0000;
  assign kp.press_ready = (state_q == ST_IDLE);
  assign kp.busy        = (state_q != ST_IDLE);
  assign kp.contact     = contact_q;
  assign kp.done        = done_q;

endmodule

// File: tb/tb_key_pad_emulator.sv
// tb/tb_key_pad_emulator.sv - self-checking bench for key_pad_emulator
module tb_key_pad_emulator;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  key_pad_emulator_if #(.HOLD_W(16)) kp ();

  key_pad_emulator #(
    .BOUNCE_CYCLES (16),
    .HOLD_W        (16),
    .LFSR_SEED     (8'hA5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .kp      (kp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] key;
    int         hold;
    logic [3:0] col;
    int         rel_at;
    bit         rotate;
    bit         rel_bounce;
    logic [3:0] exp_row;
    int         exp_busy;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int inv_err = 0;
  int exp_busy_next = 0;
  int sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected done edge is pushed at the accepting edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset_n && kp.press_req && kp.press_ready) sb.push_back(cyc + exp_busy_next);
  end

  always @(negedge clk) begin
    logic [3:0] r;
    int exp_cyc;
    if (reset_n) begin
      r = kp.row;
      if ((r & (r - 4'd1)) != 4'd0) inv_err++;
      if (r != 4'd0 && !kp.busy) inv_err++;
      if (kp.done) begin
        if (sb.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          exp_cyc = sb.pop_front();
          check("done_time", cyc, exp_cyc);
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int w = 0;
    while (!kp.press_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!kp.press_ready) check(name, 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string name);
    int w = 0;
    while (!kp.done && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!kp.done) check(name, 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int         busy_n = 0;
    bit         held_ok = 1'b1;
    bit         row_ok = 1'b1;
    logic [3:0] erow;
    wait_ready($sformatf("v%0d_ready_wait", idx));
    exp_busy_next  = v.exp_busy;
    kp.key_code    = v.key;
    kp.hold_cycles = 16'(v.hold);
    kp.col         = v.col;
    kp.press_req   = 1'b1;
    @(negedge clk);
    kp.press_req   = 1'b0;
    for (int k = 0; k < v.exp_busy + 8; k++) begin
      if (v.rotate) kp.col = 4'(4'b0001 << (k % 4));
      kp.release_now = (v.rel_at > 0 && k == 15 + v.rel_at) || (v.rel_bounce && k < 16);
      #1;
      if (kp.busy) busy_n++;
      if (k >= 16 && k < v.exp_busy - 16) begin
        if (!kp.contact) held_ok = 1'b0;
        erow = v.rotate ? ((kp.col == 4'b0100) ? v.exp_row : 4'b0000) : v.exp_row;
        if (kp.row !== erow) row_ok = 1'b0;
      end
      @(negedge clk);
    end
    kp.release_now = 1'b0;
    check($sformatf("v%0d_busy_len", idx), busy_n, v.exp_busy);
    check($sformatf("v%0d_held_contact", idx), {31'd0, held_ok}, 32'd1);
    check($sformatf("v%0d_held_row", idx), {31'd0, row_ok}, 32'd1);
  endtask

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'h6, 100,  4'b0100, 0,  1'b0, 1'b0, 4'b0010, 132};
    vecs[1] = '{4'h6, 100,  4'b0000, 0,  1'b1, 1'b0, 4'b0010, 132};
    vecs[2] = '{4'h0, 0,    4'b0001, 0,  1'b0, 1'b0, 4'b0001, 33};
    vecs[3] = '{4'h5, 1000, 4'b0010, 10, 1'b0, 1'b0, 4'b0010, 42};
    vecs[4] = '{4'hF, 5,    4'b1000, 0,  1'b0, 1'b0, 4'b1000, 37};
    vecs[5] = '{4'h9, 3,    4'b0010, 0,  1'b0, 1'b0, 4'b0100, 35};
    vecs[6] = '{4'h6, 3,    4'b0001, 0,  1'b0, 1'b0, 4'b0000, 35};
    vecs[7] = '{4'h3, 2,    4'b1111, 0,  1'b0, 1'b0, 4'b0001, 34};
    vecs[8] = '{4'hA, 20,   4'b0100, 0,  1'b0, 1'b1, 4'b0100, 52};

    kp.col = 4'b0000;
    kp.press_req = 1'b0;
    kp.key_code = 4'h0;
    kp.hold_cycles = 16'd0;
    kp.release_now = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_row", {28'd0, kp.row}, 32'd0);
    check("rst_busy", {31'd0, kp.busy}, 32'd0);
    check("rst_contact", {31'd0, kp.contact}, 32'd0);
    check("rst_done", {31'd0, kp.done}, 32'd0);
    reset_n = 1'b1;
    #1;
    check("rst_ready", {31'd0, kp.press_ready}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Back-to-back: request held high, key changed while the first press is busy
    wait_ready("b2b_ready_wait");
    exp_busy_next  = 35;
    kp.key_code    = 4'h6;
    kp.hold_cycles = 16'd3;
    kp.col         = 4'b0100;
    kp.press_req   = 1'b1;
    @(negedge clk);
    exp_busy_next  = 34;
    kp.key_code    = 4'h9;
    kp.hold_cycles = 16'd2;
    wait_done("b2b_done1_wait");
    check("b2b_ready_at_done", {30'd0, kp.press_ready, kp.busy}, 32'b10);
    @(negedge clk);
    check("b2b_second_start", {31'd0, kp.busy}, 32'd1);
    kp.press_req = 1'b0;
    kp.col = 4'b0010;
    repeat (16) @(negedge clk);
    #1;
    check("b2b_new_key_row", {28'd0, kp.row}, 32'b0100);
    wait_done("b2b_done2_wait");
    @(negedge clk);

    // Reset mid-HELD: row must drop without waiting for a clock edge
    wait_ready("rst_mid_ready_wait");
    exp_busy_next  = 1032;
    kp.key_code    = 4'h0;
    kp.hold_cycles = 16'd1000;
    kp.col         = 4'b0001;
    kp.press_req   = 1'b1;
    @(negedge clk);
    kp.press_req = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("pre_reset_row", {28'd0, kp.row}, 32'b0001);
    #1;
    reset_n = 1'b0;
    #1;
    check("reset_row_async", {28'd0, kp.row}, 32'd0);
    check("reset_busy", {31'd0, kp.busy}, 32'd0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_reset_ready", {31'd0, kp.press_ready}, 32'd1);
    repeat (40) @(negedge clk);
    check("post_reset_no_done", {31'd0, kp.done}, 32'd0);

    check("sb_empty", sb.size(), 32'd0);
    check("invariants", inv_err, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
